// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests, IF/ID register, one-entry skid buffer.
// Optional macro FETCH_MISALIGN_CHECK_EN adds a sticky misaligned-redirect flag and a HALT state.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_arst,
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall_d,
    input  logic        i_redirect,
    input  logic [63:0] i_redirect_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        o_misaligned,
`endif
    output logic        o_valid_d,
    output logic [31:0] o_instr_d,
    output logic [63:0] o_pc_d,
    output logic [63:0] o_pc_plus4_d
);

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;
`endif

    state_t      state;
    logic [63:0] pc;
    logic [63:0] skid_pc;
    logic [31:0] skid_instr;
    logic [63:0] tgt;
    logic        halted;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign tgt    = i_redirect_pc;
    assign halted = (state == S_HALT);
`else
    assign tgt    = i_redirect_pc & ~64'h3;
    assign halted = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_arst) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            skid_pc      <= '0;
            skid_instr   <= NOP_INSTR;
            o_imem_req   <= 1'b0;
            o_imem_addr  <= RESET_PC;
            o_valid_d    <= 1'b0;
            o_instr_d    <= NOP_INSTR;
            o_pc_d       <= '0;
            o_pc_plus4_d <= 64'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
            o_misaligned <= 1'b0;
`endif
        end else if (i_redirect && !halted) begin
            // Flush wins over stall: the slot holds a younger, wrong-path instruction.
            pc           <= tgt;
            o_valid_d    <= 1'b0;
            o_instr_d    <= NOP_INSTR;
            o_pc_d       <= '0;
            o_pc_plus4_d <= 64'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (|i_redirect_pc[1:0]) begin
                o_misaligned <= 1'b1;
                state        <= S_HALT;
                o_imem_req   <= 1'b0;
            end else
`endif
            if ((state == S_WAIT || state == S_DRAIN) && !i_imem_ack) begin
                // Request still in flight: keep presenting the old address until its ack.
                state      <= S_DRAIN;
                o_imem_req <= 1'b1;
            end else begin
                // A same-cycle ack (even a stale one in DRAIN) retires the old request.
                state       <= S_WAIT;
                o_imem_req  <= 1'b1;
                o_imem_addr <= tgt;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    state       <= S_WAIT;
                    o_imem_req  <= 1'b1;
                    o_imem_addr <= pc;
                end
                S_WAIT: begin
                    if (i_imem_ack) begin
                        pc          <= pc + 64'd4;
                        o_imem_addr <= pc + 64'd4;
                        if (!i_stall_d) begin
                            o_valid_d    <= 1'b1;
                            o_instr_d    <= i_imem_rdata;
                            o_pc_d       <= pc;
                            o_pc_plus4_d <= pc + 64'd4;
                        end else begin
                            skid_instr <= i_imem_rdata;
                            skid_pc    <= pc;
                            state      <= S_HOLD;
                            o_imem_req <= 1'b0;
                        end
                    end else if (!i_stall_d) begin
                        o_valid_d    <= 1'b0;
                        o_instr_d    <= NOP_INSTR;
                        o_pc_d       <= '0;
                        o_pc_plus4_d <= 64'd4;
                    end
                end
                S_HOLD: begin
                    if (!i_stall_d) begin
                        o_valid_d    <= 1'b1;
                        o_instr_d    <= skid_instr;
                        o_pc_d       <= skid_pc;
                        o_pc_plus4_d <= skid_pc + 64'd4;
                        state        <= S_WAIT;
                        o_imem_req   <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (i_imem_ack) begin
                        state       <= S_WAIT;
                        o_imem_addr <= pc;
                    end
                end
                default: ;  // HALT: parked until reset
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized memory latency, stalls and redirects checked
// against the sequential program-order stream the fetch stage must deliver to decode.
module tb_fetch_unit;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_arst = 1'b0;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        i_stall_d = 1'b0;
    logic        i_redirect = 1'b0;
    logic [63:0] i_redirect_pc = '0;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        o_valid_d;
    logic [31:0] o_instr_d;
    logic [63:0] o_pc_d;
    logic [63:0] o_pc_plus4_d;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        o_misaligned;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .i_clk(i_clk),
`ifdef FETCH_MISALIGN_CHECK_EN
        .o_misaligned(o_misaligned),
`endif
        .i_arst(i_arst),
        .o_imem_req(o_imem_req),
        .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack),
        .i_imem_rdata(i_imem_rdata),
        .i_stall_d(i_stall_d),
        .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_valid_d(o_valid_d),
        .o_instr_d(o_instr_d),
        .o_pc_d(o_pc_d),
        .o_pc_plus4_d(o_pc_plus4_d)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] tail;
    int          checks = 0;
    int          errors = 0;
    int          n_cons = 0;
    bit          saw_zero = 1'b0;

    logic        arst_v = 1'b0;
    logic        stall_v = 1'b0;
    logic        redir_v = 1'b0;
    logic [63:0] redir_pc_v = '0;
    int          fixed_lat = 0;
    bit          busy = 1'b0;
    int          cnt = 0;

    // Instruction memory contents: a few fixed words, a hash of the address elsewhere.
    function automatic logic [31:0] memf(input logic [63:0] a);
        case (a)
            64'h8000_0000: return 32'h00A0_0513;
            64'h8000_0004: return 32'h00B0_0593;
            64'h8000_0008: return 32'h0000_0013;
            default:       return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic topup();
        while (sb.size() < 16) begin
            sb.push_back('{tail, memf(tail)});
            tail = tail + 64'd4;
        end
    endtask

    task automatic fill(input logic [63:0] start);
        sb.delete();
        tail = start;
        topup();
    endtask

    // One clock cycle: drive all inputs just after the edge, including the memory
    // responder, then return at the falling edge where outputs are sampled.
    task automatic step();
        @(posedge i_clk);
        #1;
        i_arst        = arst_v;
        i_stall_d     = stall_v;
        i_redirect    = redir_v;
        i_redirect_pc = redir_pc_v;
        i_imem_ack    = 1'b0;
        i_imem_rdata  = $urandom;
        if (!arst_v) begin
            busy = 1'b0;
            fill(RESET_PC);
        end else begin
            if (o_imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                end
                if (cnt == 0) begin
                    i_imem_ack   = 1'b1;
                    i_imem_rdata = memf(o_imem_addr);
                    busy         = 1'b0;
                end else begin
                    cnt--;
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redir_v) fill(redir_pc_v);
`else
            if (redir_v) fill(redir_pc_v & ~64'h3);
`endif
        end
        @(negedge i_clk);
    endtask

    // Monitor: decode consumes the slot when valid, not stalled and not flushed.
    always @(negedge i_clk) begin
        if (i_arst) begin
            if (o_valid_d && !i_stall_d && !i_redirect) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", o_pc_d, 64'hx);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pc_d", o_pc_d, e.pc);
                    chk("instr_d", {32'h0, o_instr_d}, {32'h0, e.instr});
                    chk("pc_plus4_d", o_pc_plus4_d, e.pc + 64'd4);
                    n_cons++;
                    if (e.pc == 64'h0 && o_pc_d == 64'h0) saw_zero = 1'b1;
                    topup();
                end
            end else if (!o_valid_d) begin
                chk("bubble_instr", {32'h0, o_instr_d}, {32'h0, NOP});
                chk("bubble_pc", o_pc_d, 64'h0);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_req", o_imem_req, 0);
        chk("rst_addr", o_imem_addr, RESET_PC);
        chk("rst_valid", o_valid_d, 0);
        chk("rst_instr", {32'h0, o_instr_d}, {32'h0, NOP});
        chk("rst_pc_d", o_pc_d, 0);
        chk("rst_pc_plus4", o_pc_plus4_d, 64'd4);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_misaligned", o_misaligned, 0);
`endif
        // Zero-wait fetch after reset release
        arst_v = 1'b1;
        step();
        chk("c1_no_req", o_imem_req, 0);
        step();
        chk("c2_req", o_imem_req, 1);
        chk("c2_addr", o_imem_addr, 64'h8000_0000);
        step();
        chk("c3_valid", o_valid_d, 1);
        chk("c3_instr", {32'h0, o_instr_d}, 64'h00A0_0513);
        chk("c3_plus4", o_pc_plus4_d, 64'h8000_0004);
        chk("c3_addr", o_imem_addr, 64'h8000_0004);
        // Stall across the ack of 8000_0008
        stall_v = 1'b1;
        step();
        chk("c4_instr", {32'h0, o_instr_d}, 64'h00B0_0593);
        step();
        chk("hold_req", o_imem_req, 0);
        chk("hold_instr", {32'h0, o_instr_d}, 64'h00B0_0593);
        stall_v = 1'b0;
        step();
        chk("hold_rel_req", o_imem_req, 0);
        fixed_lat = 3;
        step();
        chk("skid_valid", o_valid_d, 1);
        chk("skid_pc", o_pc_d, 64'h8000_0008);
        chk("skid_instr", {32'h0, o_instr_d}, 64'h13);
        chk("skid_next_addr", o_imem_addr, 64'h8000_000C);
        // Redirect with a slow request outstanding
        redir_v = 1'b1; redir_pc_v = 64'h8000_0100;
        step();
        redir_v = 1'b0;
        step();
        chk("drain_valid", o_valid_d, 0);
        chk("drain_req", o_imem_req, 1);
        fixed_lat = 0;
        step();
        step();
        chk("tgt_req", o_imem_req, 1);
        chk("tgt_addr", o_imem_addr, 64'h8000_0100);
        step();
        chk("tgt_valid", o_valid_d, 1);
        chk("tgt_pc", o_pc_d, 64'h8000_0100);
        // Redirect together with ack and stall
        stall_v = 1'b1; redir_v = 1'b1; redir_pc_v = 64'h8000_0200;
        step();
        stall_v = 1'b0; redir_v = 1'b0;
        step();
        chk("flush_valid", o_valid_d, 0);
        chk("flush_instr", {32'h0, o_instr_d}, {32'h0, NOP});
        chk("flush_req", o_imem_req, 1);
        chk("flush_addr", o_imem_addr, 64'h8000_0200);
        // PC wrap
        redir_v = 1'b1; redir_pc_v = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        redir_v = 1'b0;
        repeat (10) step();
        chk("wrap_seen", saw_zero, 1);
        // Reset while a request is outstanding
        fixed_lat = 3;
        repeat (2) step();
        arst_v = 1'b0;
        step();
        arst_v = 1'b1;
        step();
        chk("mid_rst_req", o_imem_req, 0);
        chk("mid_rst_valid", o_valid_d, 0);
        chk("mid_rst_addr", o_imem_addr, RESET_PC);
        chk("mid_rst_pc_plus4", o_pc_plus4_d, 64'd4);
        // Randomized traffic
        fixed_lat = -1;
        n_cons = 0;
        for (int i = 0; i < 3000; i++) begin
            stall_v = ($urandom_range(0, 3) == 0);
            redir_v = ($urandom_range(0, 19) == 0);
`ifdef FETCH_MISALIGN_CHECK_EN
            redir_pc_v = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
`else
            redir_pc_v = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
`endif
            step();
        end
        chk("throughput", n_cons > 200, 1);
        // Misaligned redirect target
        stall_v = 1'b0; redir_v = 1'b0; fixed_lat = 0;
        repeat (6) step();
        redir_v = 1'b1; redir_pc_v = 64'h8000_0102;
        step();
        redir_v = 1'b0;
        step();
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_flag", o_misaligned, 1);
        chk("mis_valid", o_valid_d, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mis_no_req", o_imem_req, 0);
        end
`else
        chk("align_req", o_imem_req, 1);
        chk("align_addr", o_imem_addr, 64'h8000_0100);
        step();
        chk("align_pc", o_pc_d, 64'h8000_0100);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
